// File: rtl/conf_int_mac_acc_pipe_if.sv
// ---------------------------------------------------------------------------
// conf_int_mac_acc_pipe_if
// Streaming bus of the pipelined MAC: operand stream in, group results out.
//   a, b       operands (unsigned, DW bits)
//   in_valid   a/b/in_last valid
//   in_last    sample closes the current group early
//   in_ready   MAC accepts a sample this cycle
//   d          group result
//   ovf        result overflowed DW bits or accumulator wrapped
//   out_valid  d/ovf valid
//   out_ready  consumer takes d this cycle
// master: operand producer / result consumer. slave: the MAC.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface conf_int_mac_acc_pipe_if #(
    parameter int DW = 16
);
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [DW-1:0] d;
    logic          ovf;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output a, b, in_valid, in_last, out_ready,
        input  in_ready, d, ovf, out_valid
    );

    modport slave (
        input  a, b, in_valid, in_last, out_ready,
        output in_ready, d, ovf, out_valid
    );
endinterface

// File: rtl/conf_int_mac_acc_pipe.sv
// ---------------------------------------------------------------------------
// conf_int_mac_acc_pipe
// Pipelined unsigned multiply-accumulate. Accumulates a*b over groups of up
// to ACC_LEN samples (or until in_last) and emits one result per group.
// Pipeline: S1 operand register -> S2 product register -> S3 accumulator and
// output register. A pending unread result stalls the whole pipeline.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   clr_i  synchronous flush (same effect as reset, blocks in_ready)
//   bus    conf_int_mac_acc_pipe_if.slave (operand stream in, results out)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module conf_int_mac_acc_pipe #(
    parameter int OP_BITWIDTH        = 16,
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int ACC_BITWIDTH       = 40,
    parameter int ACC_LEN            = 8,
    parameter int APX_BITS           = 0,
    parameter int SATURATE           = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    conf_int_mac_acc_pipe_if.slave bus
);
    localparam int OW = OP_BITWIDTH;
    localparam int DW = DATA_PATH_BITWIDTH;
    localparam int AW = ACC_BITWIDTH;
    localparam int PW = 2 * OP_BITWIDTH;
    localparam int CW = $clog2(ACC_LEN + 1);

    localparam logic [CW-1:0] LAST_CNT = CW'(ACC_LEN - 1);
    // Approximate-operator truncation: low APX_BITS operand bits cleared.
    localparam logic [OW-1:0] APX_MASK = {OW{1'b1}} << APX_BITS;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    // Keep only the operator width, then apply the truncation mask.
    function automatic logic [OW-1:0] mask_op(input logic [DW-1:0] x);
        return OW'(x) & APX_MASK;
    endfunction

    // Input-side group tracking
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Pipeline stages
    logic          s1_v_q, s1_last_q;
    logic [OW-1:0] a1_q, b1_q;
    logic          s2_v_q, s2_last_q;
    logic [PW-1:0] prod_q;
    logic [AW-1:0] acc_q;
    logic          wrap_q;
    logic          first_q;

    // Output register
    logic [DW-1:0] d_q;
    logic          ovf_q;
    logic          out_valid_q;

    // Combinational helpers
    logic          stall_s, accept_s, close_s, load_s;
    logic [PW-1:0] prod_s;
    logic [AW-1:0] base_s;
    logic [AW:0]   sum_s;
    logic          wrap_s, big_s;

    assign stall_s      = out_valid_q & ~bus.out_ready;
    assign bus.in_ready = ~stall_s & ~clr_i;
    assign accept_s     = bus.in_valid & bus.in_ready;
    // A group closes on in_last or when the sample fills the group.
    assign close_s      = bus.in_last | (cnt_q == LAST_CNT);

    assign prod_s = PW'(a1_q) * PW'(b1_q);
    // First sample of a group starts from zero instead of the old sum.
    assign base_s = first_q ? {AW{1'b0}} : acc_q;
    assign sum_s  = {1'b0, base_s} + {{(AW + 1 - PW){1'b0}}, prod_q};
    assign wrap_s = (first_q ? 1'b0 : wrap_q) | sum_s[AW];
    assign big_s  = |sum_s[AW-1:DW];
    assign load_s = ~stall_s & s2_v_q & s2_last_q;

    assign bus.d         = d_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = out_valid_q;

    // Group-position state register
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next group position: advance on accept, return to IDLE on group close
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept_s && close_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CW{1'b0}};
                end else if (accept_s) begin
                    state_d = ST_ACCUM;
                    cnt_d   = cnt_q + CW'(1);
                end else begin
                    state_d = state_q;
                    cnt_d   = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Pipeline S1..S3; every stage holds while a result is waiting
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            s1_v_q    <= 1'b0;
            s1_last_q <= 1'b0;
            a1_q      <= {OW{1'b0}};
            b1_q      <= {OW{1'b0}};
            s2_v_q    <= 1'b0;
            s2_last_q <= 1'b0;
            prod_q    <= {PW{1'b0}};
            acc_q     <= {AW{1'b0}};
            wrap_q    <= 1'b0;
            first_q   <= 1'b1;
        end else if (!stall_s) begin
            s1_v_q <= accept_s;
            if (accept_s) begin
                a1_q      <= mask_op(bus.a);
                b1_q      <= mask_op(bus.b);
                s1_last_q <= close_s;
            end
            s2_v_q    <= s1_v_q;
            s2_last_q <= s1_last_q;
            prod_q    <= prod_s;
            if (s2_v_q) begin
                acc_q   <= sum_s[AW-1:0];
                wrap_q  <= wrap_s;
                // The sample after a group's last one starts a new group.
                first_q <= s2_last_q;
            end
        end
    end

    // Output register: load on group close, drop valid once consumed
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            d_q         <= {DW{1'b0}};
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (load_s) begin
            d_q         <= ((SATURATE != 0) && big_s) ? {DW{1'b1}} : sum_s[DW-1:0];
            ovf_q       <= big_s | wrap_s;
            out_valid_q <= 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_conf_int_mac_acc_pipe.sv
`timescale 1ns/1ps
module tb_conf_int_mac_acc_pipe;
    localparam int N = 5;

    // Instance configurations: 0: ACC_LEN=4 | 1: ACC_LEN=1,APX=2 |
    // 2: ACC_LEN=2,SAT | 3: ACC_LEN=2,wrap | 4: ACC_LEN=8
    function automatic int al_f(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            2, 3:    return 2;
            default: return 8;
        endcase
    endfunction
    function automatic int ap_f(input int i);
        return (i == 1) ? 2 : 0;
    endfunction
    function automatic int sa_f(input int i);
        return (i == 3) ? 0 : 1;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr;
    logic [15:0] a_s [N];
    logic [15:0] b_s [N];
    logic [15:0] d_s [N];
    logic        iv_s [N];
    logic        il_s [N];
    logic        ordy_s [N];
    logic        irdy_s [N];
    logic        ov_s [N];
    logic        ovf_s [N];

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          inst;
        logic [15:0] d;
        logic        ovf;
    } exp_t;
    exp_t sb_q[$];

    for (genvar gi = 0; gi < N; gi++) begin : g
        conf_int_mac_acc_pipe_if #(.DW(16)) bus ();
        assign bus.a         = a_s[gi];
        assign bus.b         = b_s[gi];
        assign bus.in_valid  = iv_s[gi];
        assign bus.in_last   = il_s[gi];
        assign bus.out_ready = ordy_s[gi];
        assign irdy_s[gi]    = bus.in_ready;
        assign d_s[gi]       = bus.d;
        assign ovf_s[gi]     = bus.ovf;
        assign ov_s[gi]      = bus.out_valid;

        conf_int_mac_acc_pipe #(
            .OP_BITWIDTH(16),
            .DATA_PATH_BITWIDTH(16),
            .ACC_BITWIDTH(40),
            .ACC_LEN(al_f(gi)),
            .APX_BITS(ap_f(gi)),
            .SATURATE(sa_f(gi))
        ) dut (
            .clk_i(clk),
            .rst_i(rst),
            .clr_i(clr),
            .bus(bus.slave)
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [15:0] d, input logic ovf);
        exp_t e;
        e.inst = k;
        e.d    = d;
        e.ovf  = ovf;
        sb_q.push_back(e);
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input int k, input logic [15:0] a, input logic [15:0] b, input logic last);
        bit ok;
        ok = 1'b0;
        a_s[k]  = a;
        b_s[k]  = b;
        il_s[k] = last;
        iv_s[k] = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = irdy_s[k];
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout inst%0d: got no accept expected accept within 50 cycles", k);
        end
        iv_s[k] = 1'b0;
        il_s[k] = 1'b0;
    endtask

    task automatic group(input int k, input int n, input logic [15:0] a, input logic [15:0] b,
                         input logic last_end);
        for (int j = 0; j < n; j++) send(k, a, b, (j == n - 1) ? last_end : 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare each consumed result with the next expectation
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (ov_s[i] && ordy_s[i]) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out inst%0d: got d=0x%0h expected no output", i, d_s[i]);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk($sformatf("out_inst%0d", i), 32'(i), 32'(e.inst));
                    chk($sformatf("d_inst%0d", i), 32'(d_s[i]), 32'(e.d));
                    chk($sformatf("ovf_inst%0d", i), 32'(ovf_s[i]), 32'(e.ovf));
                end
            end
        end
    end

    initial begin
        bit seen;
        rst = 1'b1;
        clr = 1'b0;
        for (int i = 0; i < N; i++) begin
            a_s[i] = 16'h0; b_s[i] = 16'h0; iv_s[i] = 1'b0; il_s[i] = 1'b0; ordy_s[i] = 1'b1;
        end
        idle(3);
        rst = 1'b0;

        // Reset state
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_out_valid%0d", i), 32'(ov_s[i]), 32'd0);
            chk($sformatf("rst_d%0d", i), 32'(d_s[i]), 32'd0);
            chk($sformatf("rst_ovf%0d", i), 32'(ovf_s[i]), 32'd0);
            chk($sformatf("rst_in_ready%0d", i), 32'(irdy_s[i]), 32'd1);
        end

        // 1: 2+12+30+56 = 100, result 3 cycles after the closing accept
        push(0, 16'd100, 1'b0);
        send(0, 16'd1, 16'd2, 1'b0);
        send(0, 16'd3, 16'd4, 1'b0);
        send(0, 16'd5, 16'd6, 1'b0);
        send(0, 16'd7, 16'd8, 1'b0);
        chk("latency_t1", 32'(ov_s[0]), 32'd0);
        idle(1);
        chk("latency_t2", 32'(ov_s[0]), 32'd0);
        idle(1);
        chk("latency_t3", 32'(ov_s[0]), 32'd1);

        // 2: APX_BITS=2: 7->4, 4*4=16; 3->0 gives 0
        push(1, 16'd16, 1'b0);
        send(1, 16'd7, 16'd7, 1'b0);
        push(1, 16'd0, 1'b0);
        send(1, 16'd3, 16'd9, 1'b0);

        // 3: 2*0xFFFF^2 = 0x1_FFFC_0002
        push(2, 16'hFFFF, 1'b1);
        group(2, 2, 16'hFFFF, 16'hFFFF, 1'b0);
        idle(4);
        push(3, 16'h0002, 1'b1);
        group(3, 2, 16'hFFFF, 16'hFFFF, 1'b0);

        // 4: early close 6+20=26, then a full group of eight 1s
        push(4, 16'd26, 1'b0);
        send(4, 16'd2, 16'd3, 1'b0);
        send(4, 16'd4, 16'd5, 1'b1);
        push(4, 16'd8, 1'b0);
        group(4, 8, 16'd1, 16'd1, 1'b0);
        idle(6);

        // 5: backpressure with the next sample already offered
        ordy_s[0] = 1'b0;
        push(0, 16'd16, 1'b0);
        group(0, 4, 16'd2, 16'd2, 1'b0);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            seen = ov_s[0];
        end
        chk("bp_result_seen", 32'(seen), 32'd1);
        a_s[0] = 16'd3; b_s[0] = 16'd3; iv_s[0] = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(irdy_s[0]), 32'd0);
            chk("bp_d_stable", 32'(d_s[0]), 32'd16);
            chk("bp_out_valid", 32'(ov_s[0]), 32'd1);
        end
        @(posedge clk);
        #1;
        ordy_s[0] = 1'b1;
        push(0, 16'd36, 1'b0);
        group(0, 4, 16'd3, 16'd3, 1'b0);
        idle(6);

        // 6: clr after 3 of 4 samples flushes that group
        group(0, 3, 16'd5, 16'd5, 1'b0);
        clr = 1'b1;
        @(negedge clk);
        chk("clr_in_ready", 32'(irdy_s[0]), 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        push(0, 16'd4, 1'b0);
        group(0, 4, 16'd1, 16'd1, 1'b0);
        idle(6);

        // 6b: same with rst
        group(0, 3, 16'd5, 16'd5, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        push(0, 16'd4, 1'b0);
        group(0, 4, 16'd1, 16'd1, 1'b0);
        idle(8);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
